// File: rtl/vga_sync_gen_if.sv
// Signal bundle between the clock divider, the VGA timing generator
// and the pixel renderer.
interface vga_sync_gen_if;
  logic       pixel_rate;
  logic       clk_RING;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       p_tick;
  logic       frame_start;
  logic       blink_on;

  modport master (
    input  pixel_rate, clk_RING,
    output hsync, vsync, video_on,
    output pixel_x, pixel_y,
    output p_tick, frame_start, blink_on
  );

  modport slave (
    output pixel_rate, clk_RING,
    input  hsync, vsync, video_on,
    input  pixel_x, pixel_y,
    input  p_tick, frame_start, blink_on
  );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator clocked by CLK_NX, advanced by
// rising edges of the divider's pixel_rate enable.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic CLK_NX,
  input  logic reset,
  vga_sync_gen_if.master bus
);

  localparam int H_TOTAL =
    H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL =
    V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END =
    10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END =
    10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic       r_pr_d;
  logic [1:0] r_ring_sync;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hs;
  logic       r_vs;
  logic       r_von;
  logic       r_pt;
  logic       r_fs;
  logic       r_blink;

  logic       w_tick;
  logic       w_hend;
  logic       w_wrap;
  logic [9:0] w_nx;
  logic [9:0] w_ny;

  always_comb begin
    w_tick = bus.pixel_rate & ~r_pr_d;
    w_hend = (r_x == H_LAST);
    w_wrap = w_hend && (r_y == V_LAST);
    w_nx   = w_hend ? 10'd0 : r_x + 10'd1;
    w_ny   = r_y;
    if (w_hend)
      w_ny = (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
  end

  // Decodes use the next counter values so they stay aligned with x/y.
  always_ff @(posedge CLK_NX) begin
    if (reset) begin
      r_pr_d      <= 1'b0;
      r_ring_sync <= 2'b00;
      r_x         <= 10'd0;
      r_y         <= 10'd0;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_von       <= 1'b0;
      r_pt        <= 1'b0;
      r_fs        <= 1'b0;
      r_blink     <= 1'b0;
    end else begin
      r_pr_d      <= bus.pixel_rate;
      r_ring_sync <= {r_ring_sync[0], bus.clk_RING};
      r_pt        <= w_tick;
      r_fs        <= w_tick & w_wrap;
      if (w_tick) begin
        r_x   <= w_nx;
        r_y   <= w_ny;
        r_hs  <= ~((w_nx >= HS_BEG) && (w_nx <= HS_END));
        r_vs  <= ~((w_ny >= VS_BEG) && (w_ny <= VS_END));
        r_von <= (w_nx < H_VIS) && (w_ny < V_VIS);
        if (w_wrap)
          r_blink <= r_ring_sync[1];
      end
    end
  end

  assign bus.hsync       = r_hs;
  assign bus.vsync       = r_vs;
  assign bus.video_on    = r_von;
  assign bus.pixel_x     = r_x;
  assign bus.pixel_y     = r_y;
  assign bus.p_tick      = r_pt;
  assign bus.frame_start = r_fs;
  assign bus.blink_on    = r_blink;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: full-size instance for line behaviour and a
// shrunken-geometry instance so whole frames fit in a short run.
module tb_vga_sync_gen;

  typedef struct packed {
    int hd; int hf; int hs; int hb;
    int vd; int vf; int vs; int vb;
  } geo_t;

  typedef struct packed {
    int n;
    bit started;
    bit pt;
    bit fs;
    bit blink;
  } mdl_t;

  localparam geo_t GA = '{640, 16, 96, 48, 480, 10, 2, 33};
  localparam geo_t GB = '{8, 2, 3, 3, 6, 2, 2, 2};
  localparam logic [25:0] RST_OUT = {3'b110, 20'd0, 3'b000};

  bit clk = 0;
  bit rst_v = 1;
  bit pr_v = 0;
  bit ring_v = 0;
  bit div_en = 0;
  bit pr_hold = 0;
  bit [1:0] phase = 0;
  bit pr_prev = 0;
  bit s1 = 0;
  bit s2 = 0;
  mdl_t ma = '0;
  mdl_t mb = '0;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if ifa ();
  vga_sync_gen_if ifb ();

  assign ifa.pixel_rate = pr_v;
  assign ifa.clk_RING   = ring_v;
  assign ifb.pixel_rate = pr_v;
  assign ifb.clk_RING   = ring_v;

  vga_sync_gen dut_a (
    .CLK_NX (clk),
    .reset  (rst_v),
    .bus    (ifa)
  );

  vga_sync_gen #(
    .H_DISPLAY (8), .H_FRONT (2), .H_SYNC (3), .H_BACK (3),
    .V_DISPLAY (6), .V_FRONT (2), .V_SYNC (2), .V_BACK (2)
  ) dut_b (
    .CLK_NX (clk),
    .reset  (rst_v),
    .bus    (ifb)
  );

  wire [25:0] ga = {ifa.hsync, ifa.vsync, ifa.video_on,
                    ifa.pixel_x, ifa.pixel_y,
                    ifa.p_tick, ifa.frame_start, ifa.blink_on};
  wire [25:0] gb = {ifb.hsync, ifb.vsync, ifb.video_on,
                    ifb.pixel_x, ifb.pixel_y,
                    ifb.p_tick, ifb.frame_start, ifb.blink_on};

  function automatic int htot(geo_t g);
    return g.hd + g.hf + g.hs + g.hb;
  endfunction

  function automatic int vtot(geo_t g);
    return g.vd + g.vf + g.vs + g.vb;
  endfunction

  // Position is simply the tick count modulo the frame, split into x/y.
  function automatic logic [25:0] exp_out(mdl_t m, geo_t g);
    int x = m.n % htot(g);
    int y = m.n / htot(g);
    bit hs = !(x >= g.hd + g.hf && x < g.hd + g.hf + g.hs);
    bit vs = !(y >= g.vd + g.vf && y < g.vd + g.vf + g.vs);
    bit vo = m.started && x < g.hd && y < g.vd;
    return {hs, vs, vo, 10'(x), 10'(y), m.pt, m.fs, m.blink};
  endfunction

  function automatic mdl_t m_step(mdl_t m, geo_t g, bit rst,
                                  bit tick, bit ring);
    int fr = htot(g) * vtot(g);
    mdl_t r = m;
    if (rst) return '0;
    r.pt = tick;
    r.fs = 0;
    if (tick) begin
      r.started = 1;
      if (m.n == fr - 1) begin
        r.fs = 1;
        r.blink = ring;
      end
      r.n = (m.n + 1) % fr;
    end
    return r;
  endfunction

  task automatic clk_step();
    bit tick;
    @(posedge clk);
    tick = pr_v & ~pr_prev;
    ma = m_step(ma, GA, rst_v, tick, s2);
    mb = m_step(mb, GB, rst_v, tick, s2);
    if (rst_v) begin
      pr_prev = 0; s1 = 0; s2 = 0;
    end else begin
      pr_prev = pr_v; s2 = s1; s1 = ring_v;
    end
    #1;
    phase = phase + 2'd1;
    pr_v = div_en ? phase[1] : pr_hold;
  endtask

  task automatic test_reset();
    rst_v = 1;
    div_en = 1;
    repeat (3) clk_step();
    nchk += 2;
    if (ga !== RST_OUT) begin
      nerr++;
      $display("FAIL reset_a got %h exp %h", ga, RST_OUT);
    end
    if (gb !== RST_OUT) begin
      nerr++;
      $display("FAIL reset_b got %h exp %h", gb, RST_OUT);
    end
    rst_v = 0;
  endtask

  task automatic test_first_ticks();
    int k = 0;
    while (ma.n != 1 && k < 10) begin
      clk_step();
      k++;
    end
    nchk += 1;
    if (ifa.pixel_x !== 10'd1 || ifa.video_on !== 1'b1 ||
        ifa.p_tick !== 1'b1 || ifa.hsync !== 1'b1 ||
        ifa.vsync !== 1'b1) begin
      nerr++;
      $display("FAIL first_tick got x=%0d von=%b pt=%b hs=%b vs=%b",
               ifa.pixel_x, ifa.video_on, ifa.p_tick,
               ifa.hsync, ifa.vsync);
    end
    for (int i = 0; i < 80; i++) begin
      clk_step();
      nchk += 1;
      if (ga !== exp_out(ma, GA)) begin
        nerr++;
        $display("FAIL count got %h exp %h", ga, exp_out(ma, GA));
      end
    end
  endtask

  task automatic test_line();
    int k = 0;
    while (ma.n < 810 && k < 4000) begin
      clk_step();
      k++;
      if ((k % 97) == 0) ring_v = 1'($urandom);
      nchk += 1;
      if (ga !== exp_out(ma, GA)) begin
        nerr++;
        $display("FAIL line got %h exp %h", ga, exp_out(ma, GA));
      end
      if (ma.pt && ma.n == 656) begin
        nchk += 1;
        if (ifa.hsync !== 1'b0) begin
          nerr++;
          $display("FAIL hs_fall got %b exp 0", ifa.hsync);
        end
      end
      if (ma.pt && ma.n == 752) begin
        nchk += 1;
        if (ifa.hsync !== 1'b1) begin
          nerr++;
          $display("FAIL hs_rise got %b exp 1", ifa.hsync);
        end
      end
      if (ma.pt && ma.n == 800) begin
        nchk += 1;
        if (ifa.pixel_x !== 10'd0 || ifa.pixel_y !== 10'd1) begin
          nerr++;
          $display("FAIL line_wrap got (%0d,%0d) exp (0,1)",
                   ifa.pixel_x, ifa.pixel_y);
        end
      end
    end
    nchk += 1;
    if (k >= 4000) begin
      nerr++;
      $display("FAIL line_timeout got %0d cycles exp <4000", k);
    end
  endtask

  task automatic test_frame_blink();
    int fr = htot(GB) * vtot(GB);
    int k = 0;
    int pulses = 0;
    ring_v = 1;
    while (!mb.fs && k < 4 * fr + 20) begin
      clk_step();
      k++;
      nchk += 1;
      if (gb !== exp_out(mb, GB)) begin
        nerr++;
        $display("FAIL frame got %h exp %h", gb, exp_out(mb, GB));
      end
    end
    nchk += 1;
    if (ifb.frame_start !== 1'b1 || ifb.pixel_x !== 10'd0 ||
        ifb.pixel_y !== 10'd0 || ifb.blink_on !== 1'b1) begin
      nerr++;
      $display("FAIL fs1 got fs=%b x=%0d y=%0d bl=%b exp 1,0,0,1",
               ifb.frame_start, ifb.pixel_x, ifb.pixel_y,
               ifb.blink_on);
    end
    for (int i = 0; i < 4 * fr; i++) begin
      if (i == 4 * $urandom_range(40, 150)) ring_v = 0;
      clk_step();
      pulses += int'(ifb.frame_start);
      nchk += 1;
      if (gb !== exp_out(mb, GB)) begin
        nerr++;
        $display("FAIL frame2 got %h exp %h", gb, exp_out(mb, GB));
      end
      if (!mb.fs) begin
        nchk += 1;
        if (ifb.blink_on !== 1'b1) begin
          nerr++;
          $display("FAIL blink_hold got %b exp 1", ifb.blink_on);
        end
      end
    end
    ring_v = 0;
    nchk += 2;
    if (pulses != 1) begin
      nerr++;
      $display("FAIL fs_count got %0d exp 1", pulses);
    end
    if (ifb.frame_start !== 1'b1 || ifb.blink_on !== 1'b0) begin
      nerr++;
      $display("FAIL fs2 got fs=%b bl=%b exp 1,0",
               ifb.frame_start, ifb.blink_on);
    end
  endtask

  task automatic test_freeze();
    int k = 0;
    while (!(ma.pt && ma.n % 800 == 300) && k < 4000) begin
      clk_step();
      k++;
    end
    pr_hold = 1;
    div_en = 0;
    for (int i = 0; i < 50; i++) begin
      clk_step();
      nchk += 1;
      if (ifa.pixel_x !== 10'd300 || ifa.p_tick !== 1'b0) begin
        nerr++;
        $display("FAIL freeze got x=%0d pt=%b exp 300,0",
                 ifa.pixel_x, ifa.p_tick);
      end
    end
    div_en = 1;
    k = 0;
    while (!ma.pt && k < 10) begin
      clk_step();
      k++;
    end
    nchk += 1;
    if (ifa.pixel_x !== 10'd301 || ifa.p_tick !== 1'b1) begin
      nerr++;
      $display("FAIL resume got x=%0d pt=%b exp 301,1",
               ifa.pixel_x, ifa.p_tick);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        div_en = ~div_en;
        pr_hold = 1'($urandom);
      end
      if ($urandom_range(0, 199) == 0) ring_v = ~ring_v;
      clk_step();
      nchk += 2;
      if (ga !== exp_out(ma, GA)) begin
        nerr++;
        $display("FAIL rand_a got %h exp %h", ga, exp_out(ma, GA));
      end
      if (gb !== exp_out(mb, GB)) begin
        nerr++;
        $display("FAIL rand_b got %h exp %h", gb, exp_out(mb, GB));
      end
    end
    div_en = 1;
  endtask

  task automatic test_reset_mid();
    int k = 0;
    while (mb.n / htot(GB) != 8 && k < 4000) begin
      clk_step();
      k++;
    end
    rst_v = 1;
    repeat (3) clk_step();
    nchk += 2;
    if (ga !== RST_OUT) begin
      nerr++;
      $display("FAIL rstmid_a got %h exp %h", ga, RST_OUT);
    end
    if (gb !== RST_OUT) begin
      nerr++;
      $display("FAIL rstmid_b got %h exp %h", gb, RST_OUT);
    end
    rst_v = 0;
    k = 0;
    while (!mb.pt && k < 10) begin
      clk_step();
      k++;
    end
    nchk += 2;
    if (ga !== {3'b111, 10'd1, 10'd0, 3'b100}) begin
      nerr++;
      $display("FAIL rel_a got %h exp (1,0) hs=vs=von=1", ga);
    end
    if (gb !== {3'b111, 10'd1, 10'd0, 3'b100}) begin
      nerr++;
      $display("FAIL rel_b got %h exp (1,0) hs=vs=von=1", gb);
    end
  endtask

  initial begin
    test_reset();
    test_first_ticks();
    test_line();
    test_frame_blink();
    test_freeze();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- 640x480@60 Hz VGA timing generator, directly downstream of the 100 MHz clock divider.
- Runs entirely in the CLK_NX domain. Uses the divider's pixel_rate square wave (25 MHz, toggling every 2 CLK_NX cycles) as a rising-edge-detected clock enable. It is never used as a clock.
- Produces hsync, vsync, video_on, pixel coordinates and a per-pixel strobe for the pixel/character renderer.
- Re-times the divider's 4 Hz clk_RING blink signal to frame boundaries, so blinking never tears mid-frame.

Parameters:
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BACK, 33, vertical back porch (lines)

Ports:
CLK_NX  in  1  100 MHz system clock; all logic on posedge
reset  in  1  synchronous, active-high
pixel_rate  in  1  25 MHz enable square wave from the divider
clk_RING  in  1  4 Hz blink square wave from the divider
hsync  out  1  horizontal sync, active-low
vsync  out  1  vertical sync, active-low
video_on  out  1  high while (pixel_x, pixel_y) is in the visible area
pixel_x  out  10  horizontal counter, 0..H_TOTAL-1 (H_TOTAL=800)
pixel_y  out  10  vertical counter, 0..V_TOTAL-1 (V_TOTAL=525)
p_tick  out  1  one-CLK_NX pulse per pixel advance
frame_start  out  1  one-CLK_NX pulse when the counters wrap to (0,0)
blink_on  out  1  clk_RING sampled at the last frame start

Behaviour:
- Reset:
  - pixel_x=0, pixel_y=0, hsync=1, vsync=1, video_on=0.
  - p_tick=0, frame_start=0, blink_on=0.
  - Internal pixel_rate delay register pr_d=0.
  - Reset takes priority over everything, including when it arrives mid-frame.
- Edge detect:
  - pr_d <= pixel_rate every cycle.
  - tick = pixel_rate & ~pr_d (combinational).
  - With the divider running, tick is high one cycle in every 4.
- Counters advance only on cycles with tick=1:
  - pixel_x == 799: pixel_x <= 0. Then pixel_y <= 0 if pixel_y == 524, else pixel_y + 1.
  - Otherwise: pixel_x <= pixel_x + 1. pixel_y holds.
  - With tick=0, all counters and decoded outputs hold.
- Decoded outputs are registered on the same edge as the counters, from the NEW counter values, so they are always coherent with pixel_x/pixel_y:
  - hsync=0 iff 656 <= x <= 751 (H_DISPLAY+H_FRONT .. +H_SYNC-1).
  - vsync=0 iff 490 <= y <= 491.
  - video_on = (x<640)&&(y<480). Exception: it is held 0 after reset until the first tick.
- p_tick:
  - Registered copy of tick.
  - High exactly in the cycle after the counters update.
- frame_start:
  - Registered, high for one cycle.
  - Asserted after the tick that moves the counters from (799,524) to (0,0).
  - Not asserted by reset.
- blink_on:
  - clk_RING passes through a 2-FF synchronizer.
  - On the edge that sets frame_start, blink_on <= synchronized clk_RING.
  - Otherwise blink_on holds.
- Boundaries:
  - pixel_rate stuck at 0 or 1: no ticks, so counters freeze and outputs hold.
  - Reset mid-line: next tick after release moves to (1,0).
  - All counter comparisons are unsigned 10-bit; no value outside the stated ranges is ever produced.
- Frame length: 800*525 = 420000 ticks = 1,680,000 CLK_NX cycles.

Test Plan:
- Reset, then a divider model drives pixel_rate -> p_tick pulses every 4 CLK_NX cycles. pixel_x reads 1,2,3... video_on=1 from the first tick. hsync=1, vsync=1.
- Run one line -> hsync falls when pixel_x becomes 656 and rises when it becomes 752. At tick 800, pixel_x=0 and pixel_y=1.
- Run a full frame -> vsync low exactly for pixel_y in {490,491}. video_on=0 for y>=480. frame_start pulses once after 420000 ticks, with the counters at (0,0).
- Hold clk_RING=1 across a frame boundary, then toggle it to 0 mid-frame -> blink_on=1 from the first frame_start. It stays 1 until the next frame_start, then goes 0.
- Freeze pixel_rate high for 50 cycles at pixel_x=300 -> pixel_x stays 300 and p_tick=0. On resume, counting continues at 301.
- Assert reset for 3 cycles at (700,495) -> all outputs at reset values. After release, the first tick gives (1,0) with hsync=1, vsync=1, video_on=1.
